// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared states, opcodes, ALU codes and strobe record for the control sequencer
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 5;

  typedef enum logic [3:0] {
    S_RST, F0, F1, F2, T3, T4, T5, T6, T7, S_HALT
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPCODE_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;

  typedef struct packed {
    logic       PCout;
    logic       MDRout;
    logic       RZLOout;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       BAout;
    logic       Cout;
    logic       PCin;
    logic       IRin;
    logic       MARin;
    logic       MDRin;
    logic       Yin;
    logic       RZin;
    logic       IncPC;
    logic       Read;
    logic       Write;
    logic [4:0] ops;
  } ctrl_t;

  // Halt counts as known: it is decoded, it just never reaches T4.
  function automatic logic opc_known(input logic [OPCODE_W-1:0] opc);
    case (opc)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_ADDI, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_sequencer_if.sv
// rtl/cpu_control_sequencer_if.sv - IR/memory handshake in, DataPath control strobes out
interface cpu_control_sequencer_if;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCout, MDRout, RZLOout;
  logic        gra, grb, grc, rin, rout, BAout, Cout;
  logic        PCin, IRin, MARin, MDRin, Yin, RZin;
  logic        IncPC, Read, Write;
  logic [4:0]  ops;
  logic        run, illegal, bus_err;

  // Control unit side.
  modport master (
    input  ir, mem_ready,
    output PCout, MDRout, RZLOout, gra, grb, grc, rin, rout, BAout, Cout,
           PCin, IRin, MARin, MDRin, Yin, RZin, IncPC, Read, Write,
           ops, run, illegal, bus_err
  );

  // DataPath / memory side.
  modport slave (
    output ir, mem_ready,
    input  PCout, MDRout, RZLOout, gra, grb, grc, rin, rout, BAout, Cout,
           PCin, IRin, MARin, MDRin, Yin, RZin, IncPC, Read, Write,
           ops, run, illegal, bus_err
  );
endinterface

// File: rtl/cu_output_decode.sv
// rtl/cu_output_decode.sv - combinational state + opcode to strobe vector
module cu_output_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e                i_state,
  input  logic [OPCODE_W-1:0]   i_opc,
  output ctrl_t                 o_ctrl
);

  // Moore decode: every strobe defaults low and is raised only by its step.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      F0: begin
        o_ctrl.PCout = 1'b1; o_ctrl.MARin = 1'b1; o_ctrl.IncPC = 1'b1; o_ctrl.RZin = 1'b1;
      end
      F1: begin
        o_ctrl.RZLOout = 1'b1; o_ctrl.PCin = 1'b1; o_ctrl.Read = 1'b1; o_ctrl.MDRin = 1'b1;
      end
      F2: begin
        o_ctrl.MDRout = 1'b1; o_ctrl.IRin = 1'b1;
      end
      T3: begin
        case (i_opc)
          OP_LD, OP_LDI, OP_ST: begin
            o_ctrl.grb = 1'b1; o_ctrl.BAout = 1'b1; o_ctrl.Yin = 1'b1;
          end
          OP_ADD, OP_SUB, OP_ADDI: begin
            o_ctrl.grb = 1'b1; o_ctrl.rout = 1'b1; o_ctrl.Yin = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (i_opc)
          OP_ADD, OP_SUB: begin
            o_ctrl.grc = 1'b1; o_ctrl.rout = 1'b1; o_ctrl.RZin = 1'b1; o_ctrl.ops = i_opc;
          end
          OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
            o_ctrl.Cout = 1'b1; o_ctrl.RZin = 1'b1; o_ctrl.ops = ALU_ADD;
          end
          default: ;
        endcase
      end
      T5: begin
        case (i_opc)
          OP_LD, OP_ST: begin
            o_ctrl.RZLOout = 1'b1; o_ctrl.MARin = 1'b1;
          end
          OP_LDI, OP_ADD, OP_SUB, OP_ADDI: begin
            o_ctrl.RZLOout = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.rin = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (i_opc)
          OP_LD: begin
            o_ctrl.Read = 1'b1; o_ctrl.MDRin = 1'b1;
          end
          // Read stays low so the MDR takes the bus rather than memory.
          OP_ST: begin
            o_ctrl.gra = 1'b1; o_ctrl.rout = 1'b1; o_ctrl.MDRin = 1'b1;
          end
          default: ;
        endcase
      end
      T7: begin
        case (i_opc)
          OP_LD: begin
            o_ctrl.MDRout = 1'b1; o_ctrl.gra = 1'b1; o_ctrl.rin = 1'b1;
          end
          OP_ST: o_ctrl.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// rtl/cpu_control_sequencer.sv - hardwired fetch/decode/execute sequencer; CU_MEM_TIMEOUT_EN adds memory stall timeout
module cpu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W      = 5,
  parameter int WAIT_LIMIT = 15
) (
  input  logic                     clock,
  input  logic                     clear,
  cpu_control_sequencer_if.master  bus
);

  state_e            r_state;
  logic [OPC_W-1:0]  r_opc;
  logic [OPC_W-1:0]  w_ir_opc;
  logic [OPC_W-1:0]  w_opc;
  logic              w_known;
  logic              w_mem_state;
  logic              w_unused;
  ctrl_t             w_ctrl;

  // IR is loaded at the end of F2, so it is only trusted from T3 onward;
  // T3 decodes it live and the opcode is held for the rest of the instruction.
  assign w_ir_opc    = bus.ir[31 -: OPC_W];
  assign w_opc       = (r_state == T3) ? w_ir_opc : r_opc;
  assign w_known     = opc_known(w_ir_opc);
  assign w_mem_state = (r_state == F1) ||
                       (r_state == T6 && r_opc == OP_LD) ||
                       (r_state == T7 && r_opc == OP_ST);

`ifdef CU_MEM_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_LIMIT - 1);
  logic [3:0] r_wait;
  logic       r_bus_err;
  logic       w_timeout;

  assign w_timeout = w_mem_state && !bus.mem_ready && (r_wait == WAIT_LAST);

  // Count consecutive stall cycles of the current access; latch a sticky error on expiry.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_wait    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_mem_state && !bus.mem_ready && !w_timeout) r_wait <= r_wait + 4'd1;
      else                                            r_wait <= '0;
      if (w_timeout) r_bus_err <= 1'b1;
    end
  end

  assign bus.bus_err = r_bus_err;
  assign w_unused    = ^bus.ir[31-OPC_W:0];
`else
  assign bus.bus_err = 1'b0;
  assign w_unused    = (^bus.ir[31-OPC_W:0]) ^ (WAIT_LIMIT > 0);
`endif

  // Step sequencer: fetch F0..F2, then per-opcode T3..T7, stalling on memory.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_RST;
      r_opc   <= '0;
    end else begin
      if (r_state == T3) r_opc <= w_ir_opc;
      case (r_state)
        S_RST:  r_state <= F0;
        F0:     r_state <= F1;
        F1:     if (bus.mem_ready) r_state <= F2;
        F2:     r_state <= T3;
        T3: begin
          if (w_ir_opc == OP_HALT) r_state <= S_HALT;
          else if (!w_known)       r_state <= F0;
          else                     r_state <= T4;
        end
        T4:     r_state <= T5;
        T5:     r_state <= (r_opc == OP_LD || r_opc == OP_ST) ? T6 : F0;
        T6:     if (r_opc == OP_ST || bus.mem_ready) r_state <= T7;
        T7:     if (r_opc != OP_ST || bus.mem_ready) r_state <= F0;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_RST;
      endcase
`ifdef CU_MEM_TIMEOUT_EN
      if (w_timeout) r_state <= S_HALT;
`endif
    end
  end

  cu_output_decode u_decode (
    .i_state (r_state),
    .i_opc   (w_opc),
    .o_ctrl  (w_ctrl)
  );

  assign bus.PCout   = w_ctrl.PCout;
  assign bus.MDRout  = w_ctrl.MDRout;
  assign bus.RZLOout = w_ctrl.RZLOout;
  assign bus.gra     = w_ctrl.gra;
  assign bus.grb     = w_ctrl.grb;
  assign bus.grc     = w_ctrl.grc;
  assign bus.rin     = w_ctrl.rin;
  assign bus.rout    = w_ctrl.rout;
  assign bus.BAout   = w_ctrl.BAout;
  assign bus.Cout    = w_ctrl.Cout;
  assign bus.PCin    = w_ctrl.PCin;
  assign bus.IRin    = w_ctrl.IRin;
  assign bus.MARin   = w_ctrl.MARin;
  assign bus.MDRin   = w_ctrl.MDRin;
  assign bus.Yin     = w_ctrl.Yin;
  assign bus.RZin    = w_ctrl.RZin;
  assign bus.IncPC   = w_ctrl.IncPC;
  assign bus.Read    = w_ctrl.Read;
  assign bus.Write   = w_ctrl.Write;
  assign bus.ops     = w_ctrl.ops;
  assign bus.run     = (r_state != S_RST) && (r_state != S_HALT);
  assign bus.illegal = (r_state == T3) && !w_known;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// tb/tb_cpu_control_sequencer.sv - directed and random instruction streams against a step-table model
module tb_cpu_control_sequencer;

  localparam logic [18:0] PCOUT = 19'b1 << 0,  MDROUT = 19'b1 << 1,  RZLOOUT = 19'b1 << 2;
  localparam logic [18:0] GRA   = 19'b1 << 3,  GRB    = 19'b1 << 4,  GRC     = 19'b1 << 5;
  localparam logic [18:0] RIN   = 19'b1 << 6,  ROUT   = 19'b1 << 7,  BAOUT   = 19'b1 << 8;
  localparam logic [18:0] COUT  = 19'b1 << 9,  PCIN   = 19'b1 << 10, IRIN    = 19'b1 << 11;
  localparam logic [18:0] MARIN = 19'b1 << 12, MDRIN  = 19'b1 << 13, YIN     = 19'b1 << 14;
  localparam logic [18:0] RZIN  = 19'b1 << 15, INCPC  = 19'b1 << 16, READ    = 19'b1 << 17;
  localparam logic [18:0] WRITE = 19'b1 << 18, NONE   = 19'd0;

  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_HALT = 5'b11011, A_ADD = 5'b00011, Z5 = 5'd0;

  typedef struct {
    logic [31:0] ir;
    logic        rdy;
    logic [18:0] s;
    logic [4:0]  ops;
    logic        run, ill, err;
    int          step;
  } cyc_t;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;
  cyc_t q[$];

  cpu_control_sequencer_if bus();

  cpu_control_sequencer #(.OPC_W(5), .WAIT_LIMIT(15)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic is_def(input logic [4:0] opc);
    return opc inside {OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_ADDI, OP_HALT};
  endfunction

  task automatic check(input logic [26:0] exp, input logic [4:0] opc, input int step);
    logic [26:0] obs;
    obs = {bus.Write, bus.Read, bus.IncPC, bus.RZin, bus.Yin, bus.MDRin, bus.MARin,
           bus.IRin, bus.PCin, bus.Cout, bus.BAout, bus.rout, bus.rin, bus.grc,
           bus.grb, bus.gra, bus.RZLOout, bus.MDRout, bus.PCout,
           bus.ops, bus.run, bus.illegal, bus.bus_err};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL ctrl op=%b step=%0d observed=%h expected=%h", opc, step, obs, exp);
    end
  endtask

  // One step of an instruction; memory steps repeat once per stall with mem_ready low.
  task automatic add_step(input logic [31:0] ir, input logic [18:0] s, input logic [4:0] ops,
                          input logic ill, input logic is_mem, input int stalls, input int step);
    cyc_t e;
    e.ir = ir; e.s = s; e.ops = ops; e.run = 1'b1; e.ill = ill; e.err = 1'b0; e.step = step;
    for (int k = 0; k < stalls; k++) begin
      e.rdy = 1'b0;
      q.push_back(e);
    end
    e.rdy = is_mem ? 1'b1 : 1'($urandom_range(0, 1));
    q.push_back(e);
  endtask

  task automatic add_halt(input logic [31:0] ir, input int n, input logic err);
    cyc_t e;
    e.ir = ir; e.s = NONE; e.ops = Z5; e.run = 1'b0; e.ill = 1'b0; e.err = err; e.step = 8;
    for (int k = 0; k < n; k++) begin
      e.rdy = 1'($urandom_range(0, 1));
      q.push_back(e);
    end
  endtask

  task automatic add_instr(input logic [31:0] ir, input int s_f1, input int s_mem);
    logic [4:0] opc;
    opc = ir[31:27];
    add_step(ir, PCOUT | MARIN | INCPC | RZIN, Z5, 1'b0, 1'b0, 0, 0);
    add_step(ir, RZLOOUT | PCIN | READ | MDRIN, Z5, 1'b0, 1'b1, s_f1, 1);
    add_step(ir, MDROUT | IRIN, Z5, 1'b0, 1'b0, 0, 2);
    case (opc)
      OP_LD, OP_LDI, OP_ST: begin
        add_step(ir, GRB | BAOUT | YIN, Z5, 1'b0, 1'b0, 0, 3);
        add_step(ir, COUT | RZIN, A_ADD, 1'b0, 1'b0, 0, 4);
        if (opc == OP_LDI) begin
          add_step(ir, RZLOOUT | GRA | RIN, Z5, 1'b0, 1'b0, 0, 5);
        end else begin
          add_step(ir, RZLOOUT | MARIN, Z5, 1'b0, 1'b0, 0, 5);
          if (opc == OP_LD) begin
            add_step(ir, READ | MDRIN, Z5, 1'b0, 1'b1, s_mem, 6);
            add_step(ir, MDROUT | GRA | RIN, Z5, 1'b0, 1'b0, 0, 7);
          end else begin
            add_step(ir, GRA | ROUT | MDRIN, Z5, 1'b0, 1'b0, 0, 6);
            add_step(ir, WRITE, Z5, 1'b0, 1'b1, s_mem, 7);
          end
        end
      end
      OP_ADD, OP_SUB, OP_ADDI: begin
        add_step(ir, GRB | ROUT | YIN, Z5, 1'b0, 1'b0, 0, 3);
        if (opc == OP_ADDI) add_step(ir, COUT | RZIN, A_ADD, 1'b0, 1'b0, 0, 4);
        else                add_step(ir, GRC | ROUT | RZIN, opc, 1'b0, 1'b0, 0, 4);
        add_step(ir, RZLOOUT | GRA | RIN, Z5, 1'b0, 1'b0, 0, 5);
      end
      OP_HALT: add_step(ir, NONE, Z5, 1'b0, 1'b0, 0, 3);
      default: add_step(ir, NONE, Z5, 1'b1, 1'b0, 0, 3);
    endcase
  endtask

  task automatic run_n(input int n);
    cyc_t e;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      e = q.pop_front();
      @(posedge clock);
      #1;
      bus.ir = e.ir;
      bus.mem_ready = e.rdy;
      #1;
      check({e.s, e.ops, e.run, e.ill, e.err}, e.ir[31:27], e.step);
    end
  endtask

  task automatic run_all();
    run_n(q.size());
  endtask

  // Asynchronous clear in the middle of a cycle, held across one edge, then released.
  task automatic do_reset();
    #1 clear = 1'b1;
    #1 check(27'd0, Z5, -1);
    @(posedge clock);
    #1 check(27'd0, Z5, -2);
    clear = 1'b0;
    #1 check(27'd0, Z5, -3);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc);
    return {opc, 27'($urandom)};
  endfunction

  initial begin
    logic [4:0] opc;
    int         kind;
    bus.ir = 32'd0;
    bus.mem_ready = 1'b1;
    #1 clear = 1'b1;
    #1 check(27'd0, Z5, -1);
    @(posedge clock);
    #1 clear = 1'b0;
    #1 check(27'd0, Z5, -3);

    add_instr(mk(OP_LD), 0, 0);
    add_instr(mk(OP_LDI), 0, 0);
    add_instr(mk(OP_ADDI), 0, 0);
    add_instr(mk(OP_ST), 0, 3);
    add_instr(mk(OP_ADD), 0, 0);
    add_instr(mk(OP_SUB), 0, 0);
    add_instr(mk(5'b11111), 0, 0);
    add_instr(mk(OP_LD), 2, 2);
    run_all();

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: opc = OP_LD;
        1: opc = OP_LDI;
        2: opc = OP_ST;
        3: opc = OP_ADD;
        4: opc = OP_SUB;
        5: opc = OP_ADDI;
        default: begin
          opc = 5'($urandom_range(0, 31));
          while (is_def(opc)) opc = 5'($urandom_range(0, 31));
        end
      endcase
      add_instr(mk(opc), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    run_all();

    add_instr(mk(OP_LD), 0, 2);
    run_n(7);
    q.delete();
    do_reset();
    add_instr(mk(OP_ADD), 1, 0);
    run_all();

    add_instr(mk(OP_HALT), 0, 0);
    add_halt(mk(OP_LDI), 20, 1'b0);
    run_all();
    do_reset();

`ifdef CU_MEM_TIMEOUT_EN
    add_step(32'd0, PCOUT | MARIN | INCPC | RZIN, Z5, 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 15; k++) begin
      cyc_t e;
      e.ir = 32'd0; e.rdy = 1'b0; e.s = RZLOOUT | PCIN | READ | MDRIN; e.ops = Z5;
      e.run = 1'b1; e.ill = 1'b0; e.err = 1'b0; e.step = 1;
      q.push_back(e);
    end
    add_halt(32'd0, 5, 1'b1);
    run_all();
`else
    add_instr(mk(OP_LDI), 20, 0);
    run_all();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
- Hardwired control unit for the single-bus CPU datapath; replaces bench-driven control strobes.
- Fetches, decodes `ir`, and steps T0..T7 micro-steps, driving bus-out, register-in, ALU-op and memory strobes for ld, ldi, st, add, sub, addi and halt.
- Sits beside the DataPath. All outputs wire directly to the same-named DataPath inputs.

Parameters:
- OPC_W, 5: opcode width, taken from `ir[31:27]`.
- WAIT_LIMIT, 15: maximum stall cycles on one memory access. Used only with the optional feature.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous active-high reset.
- ir  in  32  IR register contents.
- mem_ready  in  1  memory completes Read/Write this cycle.
- PCout, MDRout, RZLOout  out  1 each  bus drivers.
- gra, grb, grc, rin, rout, BAout, Cout  out  1 each  register-select and bus control.
- PCin, IRin, MARin, MDRin, Yin, RZin  out  1 each  register load enables.
- IncPC, Read, Write  out  1 each  PC increment and memory strobes.
- ops  out  5  ALU operation code.
- run  out  1  high while executing.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- bus_err  out  1  sticky; set on memory timeout.

Behaviour:
- Outputs are Moore-decoded from the registered state, asserted for the whole cycle, and default to 0.
- Reset (async, any time, including mid-instruction):
  - state = S_RST; every output 0, `ops` = 0, `run` = 0, `bus_err` = 0.
  - The first rising edge after `clear` falls moves S_RST -> F0. `run` = 1 in every state except S_RST and S_HALT.
- Fetch:
  - F0: PCout, MARin, IncPC, RZin.
  - F1: RZLOout, PCin, Read, MDRin. Stalls while mem_ready = 0.
  - F2: MDRout, IRin.
  - F2 -> T3 decodes `ir[31:27]` one cycle later, so the IR value is valid.
- Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, addi 01100, halt 11011. ALU op code ADD = 00011.
- ld:
  - T3: grb, BAout, Yin.
  - T4: Cout, ops = ADD, RZin.
  - T5: RZLOout, MARin.
  - T6: Read, MDRin (stall).
  - T7: MDRout, gra, rin -> F0.
- ldi: T3 and T4 as ld; T5: RZLOout, gra, rin -> F0.
- st:
  - T3..T5 as ld.
  - T6: gra, rout, MDRin (Read = 0 selects the bus).
  - T7: Write (stall) -> F0.
- add / sub:
  - T3: grb, rout, Yin.
  - T4: grc, rout, ops = ir[31:27], RZin.
  - T5: RZLOout, gra, rin -> F0.
- addi:
  - T3: grb, rout, Yin.
  - T4: Cout, ops = ADD, RZin.
  - T5: RZLOout, gra, rin -> F0.
- halt: T3 -> S_HALT. S_HALT is absorbing (run = 0) until `clear`.
- Undefined opcode: `illegal` = 1 for the T3 cycle, then -> F0; no register write.
- Stall: in F1/T6/T7-st, while mem_ready = 0 the state holds and strobes stay asserted. Advance on the first cycle with mem_ready = 1.
- `ops` holds its value only in T4; 0 elsewhere.
- Instruction cycle counts with mem_ready tied high:
  - ld: 8.
  - ldi, add, sub, addi: 6.
  - st: 8.

Optional Feature:
- Macro CU_MEM_TIMEOUT_EN.
- Enabled:
  - A 4-bit stall counter resets on entering any memory state and increments on each mem_ready = 0 cycle.
  - When the count reaches WAIT_LIMIT with mem_ready still 0: `bus_err` is set (sticky), all strobes drop next cycle, and state -> S_HALT.
- Disabled: no counter, `bus_err` tied 0, stalls are unbounded.

Decomposition:
- Shared package `cpu_ctrl_pkg`:
  - State enum (S_RST, F0..F2, T3..T7, S_HALT).
  - Opcode localparams.
  - ALU op constants (ADD = 5'b00011, SUB = 5'b00100).
- One sub-module, `cu_output_decode`: purely combinational state + opcode -> strobe vector.
- The top-level keeps the state register, stall/timeout logic and the `illegal` pulse.

Test Plan:
- clear pulse, then `ir` = ld (opcode 00000), mem_ready = 1 -> strobe sequence F0..T7 exactly as specified. T4 has ops = 00011. 8 cycles, then back in F0.
- ldi, then addi, mem_ready = 1 -> each takes 6 cycles. T5 asserts RZLOout, gra and rin together. No Read in T3..T5.
- st with mem_ready = 0 for 3 cycles in T7 -> Write held for 4 cycles total, then F0. Gives 11-cycle instruction.
- add then sub -> T4 `ops` = 00011 then 00100. grc and rout are high only in T4.
- `ir` opcode 11111 -> `illegal` high for exactly one cycle, then F0. Opcode 11011 -> run = 0, state held 20 cycles, all strobes 0.
- clear asserted asynchronously mid-T6 of ld -> all outputs 0 within the same cycle. F0 follows the first rising edge after release.
- CU_MEM_TIMEOUT_EN defined, mem_ready stuck 0 in F1 -> `bus_err` rises after 15 stall cycles, then S_HALT, run = 0.
